// File: rtl/perceptron_trainer.sv
// Single-layer perceptron trained on-chip against a binary truth table.
// One sample costs two cycles: EVAL registers the prediction, UPDATE applies the saturating weight step.
module perceptron_trainer #(
    parameter int N_INPUTS   = 2,
    parameter int WIDTH      = 16,
    parameter int FRAC       = 8,
    parameter int MAX_EPOCHS = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WIDTH-1:0]            lr,
    input  logic [2**N_INPUTS-1:0]      truth_table,
    input  logic [N_INPUTS-1:0]         infer_in,
    output logic                        infer_out,
    output logic                        busy,
    output logic                        done,
    output logic                        converged,
    output logic [7:0]                  epoch_count,
    output logic [N_INPUTS*WIDTH-1:0]   weights,
    output logic [WIDTH-1:0]            bias
);

    localparam int SW = WIDTH + 3;
    localparam logic [N_INPUTS-1:0]     K_LAST = '1;
    localparam logic signed [WIDTH-1:0] S_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, EVAL, UPDATE, DONE} state_t;

    state_t                    state, state_nxt;
    logic signed [WIDTH-1:0]   w_q [N_INPUTS];
    logic signed [WIDTH-1:0]   bias_q, lr_q;
    logic [N_INPUTS-1:0]       k;
    logic [N_INPUTS:0]         err_cnt, err_total;
    logic                      pred_q, err_now, last_sample, max_hit;
    logic [7:0]                epoch_next;
    logic signed [SW-1:0]      train_sum, infer_sum;
    logic                      train_pos, infer_pos;

    // FRAC only fixes where the binary point sits; the arithmetic is scale-free.
    logic unused_frac;
    assign unused_frac = (FRAC < WIDTH);

    function automatic logic signed [WIDTH-1:0] sat_step(
        input logic signed [WIDTH-1:0] val,
        input logic signed [WIDTH-1:0] step,
        input logic                    sub
    );
        logic signed [WIDTH:0] r;
        r = sub ? ({val[WIDTH-1], val} - {step[WIDTH-1], step})
                : ({val[WIDTH-1], val} + {step[WIDTH-1], step});
        if (r[WIDTH] != r[WIDTH-1])
            return r[WIDTH] ? S_MIN : S_MAX;
        return r[WIDTH-1:0];
    endfunction

    // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        train_sum = {{3{bias_q[WIDTH-1]}}, bias_q};
        infer_sum = {{3{bias_q[WIDTH-1]}}, bias_q};
        for (int i = 0; i < N_INPUTS; i++) begin
            if (k[i])        train_sum = train_sum + {{3{w_q[i][WIDTH-1]}}, w_q[i]};
            if (infer_in[i]) infer_sum = infer_sum + {{3{w_q[i][WIDTH-1]}}, w_q[i]};
        end
    end

    assign train_pos   = !train_sum[SW-1] && (train_sum != '0);
    assign infer_pos   = !infer_sum[SW-1] && (infer_sum != '0);
    assign err_now     = truth_table[k] != pred_q;
    assign err_total   = err_cnt + (N_INPUTS+1)'(err_now);
    assign last_sample = (k == K_LAST);
    assign epoch_next  = epoch_count + 8'd1;
    assign max_hit     = (epoch_next == 8'(MAX_EPOCHS));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = EVAL;
            EVAL:       state_nxt = UPDATE;
            UPDATE: begin
                if (!last_sample)
                    state_nxt = EVAL;
                else if (err_total == '0 || max_hit)
                    state_nxt = DONE;
                else
                    state_nxt = EVAL;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    // NOTE: the weights are a handful of flops rather than a RAM, so clearing them in reset is legal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            for (int i = 0; i < N_INPUTS; i++) w_q[i] <= '0;
            bias_q      <= '0;
            lr_q        <= '0;
            k           <= '0;
            err_cnt     <= '0;
            epoch_count <= '0;
            converged   <= 1'b0;
            pred_q      <= 1'b0;
            infer_out   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            case (state)
                IDLE, DONE: begin
                    infer_out <= infer_pos;
                    if (start) begin
                        for (int i = 0; i < N_INPUTS; i++) w_q[i] <= '0;
                        bias_q      <= '0;
                        lr_q        <= lr;
                        k           <= '0;
                        err_cnt     <= '0;
                        epoch_count <= '0;
                        converged   <= 1'b0;
                        infer_out   <= 1'b0;
                    end
                end
                EVAL: begin
                    pred_q    <= train_pos;
                    infer_out <= 1'b0;
                end
                UPDATE: begin
                    infer_out <= 1'b0;
                    // err = -1 exactly when the prediction was 1, so pred selects subtract.
                    if (err_now) begin
                        bias_q <= sat_step(bias_q, lr_q, pred_q);
                        for (int i = 0; i < N_INPUTS; i++)
                            if (k[i]) w_q[i] <= sat_step(w_q[i], lr_q, pred_q);
                    end
                    if (!last_sample) begin
                        k       <= k + 1'b1;
                        err_cnt <= err_total;
                    end else begin
                        epoch_count <= epoch_next;
                        if (err_total == '0) begin
                            converged <= 1'b1;
                        end else if (max_hit) begin
                            converged <= 1'b0;
                        end else begin
                            k       <= '0;
                            err_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == EVAL) || (state == UPDATE);
    assign done = (state == DONE);
    assign bias = bias_q;

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_weights
        assign weights[i*WIDTH +: WIDTH] = w_q[i];
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Randomized scoreboard bench for perceptron_trainer: expected training outcomes are queued at start
// and compared by an independent monitor when done rises.
module tb_perceptron_trainer;

    localparam int N    = 2;
    localparam int W    = 16;
    localparam int T    = 4;
    localparam int MAXE = 10;

    typedef struct packed {
        logic         conv;
        logic [7:0]   epochs;
        logic [15:0]  cycles;
        logic [N*W-1:0] weights;
        logic [W-1:0] bias;
    } exp_t;

    logic           clk, rst, start;
    logic [W-1:0]   lr;
    logic [T-1:0]   truth_table;
    logic [N-1:0]   infer_in;
    logic           infer_out, busy, done, converged;
    logic [7:0]     epoch_count;
    logic [N*W-1:0] weights;
    logic [W-1:0]   bias;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    perceptron_trainer #(.N_INPUTS(N), .WIDTH(W), .FRAC(8), .MAX_EPOCHS(MAXE)) dut (
        .clk(clk), .rst(rst), .start(start), .lr(lr), .truth_table(truth_table),
        .infer_in(infer_in), .infer_out(infer_out), .busy(busy), .done(done),
        .converged(converged), .epoch_count(epoch_count), .weights(weights), .bias(bias)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int clamp(input int x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // Plain perceptron learning rule, run epoch by epoch over all patterns.
    function automatic exp_t model(input logic [W-1:0] lr_v, input logic [T-1:0] tt);
        int   w [N];
        int   b, lrv, errs, sum, d, ep, tmp;
        exp_t r;
        lrv = int'($signed(lr_v));
        b   = 0;
        ep  = 0;
        for (int i = 0; i < N; i++) w[i] = 0;
        do begin
            ep++;
            errs = 0;
            for (int p = 0; p < T; p++) begin
                sum = b;
                for (int i = 0; i < N; i++) if (((p >> i) & 1) == 1) sum += w[i];
                if (int'(tt[p]) != int'(sum > 0)) begin
                    d = tt[p] ? lrv : -lrv;
                    b = clamp(b + d);
                    for (int i = 0; i < N; i++) if (((p >> i) & 1) == 1) w[i] = clamp(w[i] + d);
                    errs++;
                end
            end
        end while (errs != 0 && ep < MAXE);
        r.conv   = (errs == 0);
        r.epochs = 8'(ep);
        r.cycles = 16'(2 * T * ep);
        r.bias   = b[W-1:0];
        for (int i = 0; i < N; i++) begin
            tmp = w[i];
            r.weights[i*W +: W] = tmp[W-1:0];
        end
        return r;
    endfunction

    function automatic logic infer_model(input exp_t r, input logic [N-1:0] x);
        int s;
        s = int'($signed(r.bias));
        for (int i = 0; i < N; i++) if (x[i]) s += int'($signed(r.weights[i*W +: W]));
        return s > 0;
    endfunction

    // Monitor: compares each finished training run against the head of the scoreboard.
    initial begin
        int   busy_cnt;
        logic done_q;
        exp_t e;
        busy_cnt = 0;
        done_q   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
                done_q   = 1'b0;
            end else begin
                if (busy) begin
                    busy_cnt++;
                    check("infer_out_while_busy", 64'(infer_out), 64'd0);
                end
                if (done && !done_q) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("converged",   64'(converged),   64'(e.conv));
                        check("epoch_count", 64'(epoch_count), 64'(e.epochs));
                        check("weights",     64'(weights),     64'(e.weights));
                        check("bias",        64'(bias),        64'(e.bias));
                        check("busy_cycles", 64'(busy_cnt),    64'(e.cycles));
                    end
                    busy_cnt = 0;
                end
                done_q = done;
            end
        end
    end

    task automatic launch(input logic [W-1:0] lr_v, input logic [T-1:0] tt, input bit score,
                          output exp_t r);
        @(negedge clk);
        lr          = lr_v;
        truth_table = tt;
        start       = 1'b1;
        r           = model(lr_v, tt);
        if (score) exp_q.push_back(r);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done while scrambling lr and pulsing start; both must be ignored mid-training.
    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!done && cyc < 1000) begin
            lr    = W'($urandom);
            start = busy && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_infer(input exp_t r, input string tag);
        for (int p = 0; p < T; p++) begin
            infer_in = N'(p);
            @(negedge clk);
            check({tag, "_infer"}, 64'(infer_out), 64'(infer_model(r, N'(p))));
        end
    endtask

    task automatic run_job(input logic [W-1:0] lr_v, input logic [T-1:0] tt, output exp_t r);
        launch(lr_v, tt, 1'b1, r);
        wait_done();
        check_infer(r, "job");
    endtask

    task automatic check_and_result();
        check("and_converged", 64'(converged),   64'd1);
        check("and_epochs",    64'(epoch_count), 64'd6);
        check("and_weights",   64'(weights),     64'h0200_0100);
        check("and_bias",      64'(bias),        64'hFE00);
        for (int p = 0; p < T; p++) begin
            infer_in = N'(p);
            @(negedge clk);
            check("and_infer", 64'(infer_out), (p == 3) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        exp_t r;
        rst         = 1'b1;
        start       = 1'b0;
        lr          = '0;
        truth_table = '0;
        infer_in    = '1;
        #1;
        check("reset_outputs", 64'({busy, done, converged, infer_out, epoch_count, weights, bias}), 64'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_infer_zero", 64'(infer_out), 64'd0);
        check("idle_not_busy",   64'({busy, done}), 64'd0);

        // AND: converges in six epochs to the documented weights.
        launch(16'h0100, 4'b1000, 1'b1, r);
        wait_done();
        check_and_result();

        // XOR: never separable, stops at the epoch limit.
        run_job(16'h0100, 4'b0110, r);
        check("xor_converged", 64'(converged),   64'd0);
        check("xor_epochs",    64'(epoch_count), 64'd10);

        // All-zero target: one clean epoch, nothing learned.
        run_job(W'($urandom), 4'b0000, r);
        check("zero_epochs",  64'(epoch_count), 64'd1);
        check("zero_weights", 64'({weights, bias}), 64'd0);

        // Full-scale learning rate drives weights and bias into the clamps.
        run_job(16'h7FFF, 4'b1110, r);
        run_job(16'h7FFF, 4'b0110, r);
        run_job(16'h8000, 4'b1001, r);

        // Reset in the middle of the second epoch, then a clean AND rerun.
        launch(16'h0100, 4'b1000, 1'b0, r);
        repeat (11) @(negedge clk);
        check("mid_epoch2_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs",
              64'({busy, done, converged, infer_out, epoch_count, weights, bias}), 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_idle", 64'({busy, done, epoch_count}), 64'd0);
        launch(16'h0100, 4'b1000, 1'b1, r);
        wait_done();
        check_and_result();

        for (int j = 0; j < 24; j++) begin
            logic [W-1:0] lr_v;
            case ($urandom_range(0, 3))
                0:       lr_v = W'($urandom_range(1, 16'h0400));
                1:       lr_v = W'(-$urandom_range(1, 16'h0400));
                2:       lr_v = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
                default: lr_v = W'($urandom);
            endcase
            run_job(lr_v, T'($urandom), r);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/perceptron_trainer.md
PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 SHALL have parameter N_INPUTS, default 2, number of binary perceptron inputs; legal range 1..4.
REQ-002 SHALL have parameter WIDTH, default 16, signed fixed-point word width for weights, bias and lr.
REQ-003 SHALL have parameter FRAC, default 8, fractional bits of the fixed-point format; 1.0 = 1<<FRAC.
REQ-004 SHALL have parameter MAX_EPOCHS, default 10, upper bound on training epochs; legal range 1..255.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  single-cycle training request.
REQ-008 SHALL have port lr  input  WIDTH  signed learning rate, sampled on accepted start.
REQ-009 SHALL have port truth_table  input  2**N_INPUTS  target function; bit k is the expected output for input pattern k.
REQ-010 SHALL have port infer_in  input  N_INPUTS  live input pattern for inference.
REQ-011 SHALL have port infer_out  output  1  registered inference result.
REQ-012 SHALL have port busy  output  1  high while training.
REQ-013 SHALL have port done  output  1  high while in DONE.
REQ-014 SHALL have port converged  output  1  valid when done; 1 = last epoch had zero errors.
REQ-015 SHALL have port epoch_count  output  8  number of completed epochs.
REQ-016 SHALL have port weights  output  N_INPUTS*WIDTH  weight i at bits [i*WIDTH +: WIDTH].
REQ-017 SHALL have port bias  output  WIDTH  current bias.

Function
REQ-018 SHALL implement states IDLE, EVAL, UPDATE, DONE.
REQ-019 SHALL accept start only in IDLE or DONE; on acceptance: weights, bias, epoch_count, sample index k and epoch error count cleared to 0; lr latched; state to EVAL.
REQ-020 SHALL ignore start in EVAL and UPDATE; lr and truth_table changes have no effect on an epoch already in progress, except that truth_table SHALL be read live each EVAL.
REQ-021 SHALL in EVAL form x_i = bit i of k; sum = bias + sum of weight_i where x_i=1, computed at WIDTH+3 bits with no overflow; pred = (sum > 0), strictly greater; register pred; go to UPDATE.
REQ-022 SHALL in UPDATE take err = truth_table[k] - pred. On +1, add lr to bias and to each weight_i with x_i=1; on -1, subtract; on 0, no change. Increment error count when err != 0.
REQ-023 SHALL saturate each weight and bias update to the signed WIDTH range, never wrap.
REQ-024 SHALL, in UPDATE with k < 2**N_INPUTS-1, increment k and return to EVAL.
REQ-025 SHALL, in UPDATE with k = 2**N_INPUTS-1, increment epoch_count; then:
- if this epoch's error count, including this sample, is 0: converged=1, go to DONE
- else if epoch_count reaches MAX_EPOCHS: converged=0, go to DONE
- else clear k and the error count and go to EVAL.
REQ-026 SHALL take exactly 2 cycles per sample; one epoch = 2*2**N_INPUTS cycles.
REQ-027 SHALL drive busy=1 in EVAL and UPDATE; done=1 only in DONE; converged held until the next accepted start.
REQ-028 SHALL in IDLE and DONE register infer_out = (bias + sum of weight_i where infer_in[i]=1) > 0 every cycle, 1-cycle latency; infer_out held 0 while busy.
REQ-029 SHALL keep weights and bias stable in IDLE and DONE; a negative lr is legal and applied as-is.

Reset
REQ-030 SHALL on rst asserted, at any time including mid-epoch, immediately force state IDLE and clear weights, bias, epoch_count, k, error count, converged, busy, done and infer_out to 0.
REQ-031 SHALL remain in IDLE after rst deasserts until start; infer_out then evaluates zero weights and reads 0.

Verification
REQ-032 N=2, WIDTH=16, FRAC=8, lr=0x0100, truth_table=4'b1000 (AND), start -> done after 48 cycles in EVAL/UPDATE, converged=1, epoch_count=6, weights={w1=0x0200,w0=0x0100}, bias=0xFE00; infer_in=2'b11 -> infer_out=1 next cycle, other patterns -> 0.
REQ-033 Same with truth_table=4'b0110 (XOR), MAX_EPOCHS=10 -> done after 80 cycles, converged=0, epoch_count=10.
REQ-034 truth_table=4'b0000, any lr -> converged=1, epoch_count=1 after 8 cycles; weights and bias remain 0.
REQ-035 lr=0x7FFF, truth_table=4'b1110 (OR), inject a repeated-error pattern -> weights and bias clamp at 0x7FFF/0x8000, never wrap.
REQ-036 rst pulsed mid-epoch 2 -> all outputs 0 asynchronously; start pulses during busy ignored; a new start after reset reruns REQ-032 with identical results.
